quiz_arbiter_timer: RTL and testbench

- Upstream control stage of the quiz responder. It arbitrates 8 player keys and detects early-press fouls.
- It runs the BCD countdown and drives the display stage's Player_Number, TimerH and TimerL inputs.
- It also produces the lock, timeout, foul and buzzer status signals.
- All outputs are registered and stable between updates, so the display scan samples them asynchronously to its own refresh.

---
 rtl/quiz_arbiter_timer.sv | 118 +++++++++++
 tb/tb_quiz_arbiter_timer.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/quiz_arbiter_timer.sv
// quiz_arbiter_timer: 8-key arbitration, early-press foul detection and BCD countdown for the quiz responder
module quiz_arbiter_timer #(
  parameter int         TICK_DIV    = 50_000_000,
  parameter logic [7:0] GRAB_TIME   = 8'h20,
  parameter logic [7:0] ANSWER_TIME = 8'h30
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       Host_Start,
  input  logic       Host_Clear,
  input  logic [7:0] Player_Key,
  output logic [3:0] Player_Number,
  output logic [3:0] TimerH,
  output logic [3:0] TimerL,
  output logic       Lock_Out,
  output logic       Timeout_Out,
  output logic       Foul_Out,
  output logic       Buzzer_Out
);
  localparam int TW = $clog2(TICK_DIV);
  localparam int BW = $clog2(TICK_DIV + 1);
  typedef enum logic [2:0] {IDLE, ARMED, LOCKED, TIMEOUT, FOUL} state_t;
  state_t        state;
  logic [TW-1:0] tick_cnt;
  logic [BW-1:0] buzz_cnt;
  logic [7:0]    key_d, key_rise, timer, timer_dec;
  logic          start_d, start_rise, timing, tick;
  logic [3:0]    pick;
  assign key_rise   = Player_Key & ~key_d;
  assign start_rise = Host_Start & ~start_d;
  assign timing     = state == ARMED || state == LOCKED;
  assign tick       = timing && tick_cnt == TW'(TICK_DIV - 1);
  assign timer      = {TimerH, TimerL};
  assign timer_dec  = timer == 8'h00 ? 8'h00 :
                      TimerL == 4'd0 ? {TimerH - 4'd1, 4'd9} : {TimerH, TimerL - 4'd1};
  // lowest-numbered rising key wins
  always_comb begin
    pick = 4'd0;
    for (int i = 7; i >= 0; i--) if (key_rise[i]) pick = 4'(i + 1);
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state         <= IDLE;
      Player_Number <= 4'd0;
      {TimerH, TimerL} <= GRAB_TIME;
      Lock_Out      <= 1'b0;
      Timeout_Out   <= 1'b0;
      Foul_Out      <= 1'b0;
      Buzzer_Out    <= 1'b0;
      buzz_cnt      <= '0;
      tick_cnt      <= '0;
      key_d         <= 8'd0;
      start_d       <= 1'b0;
    end else begin
      key_d    <= Player_Key;
      start_d  <= Host_Start;
      tick_cnt <= timing && !tick ? tick_cnt + 1'b1 : '0;
      if (buzz_cnt != '0) begin
        buzz_cnt   <= buzz_cnt - 1'b1;
        Buzzer_Out <= buzz_cnt != BW'(1);
      end
      if (Host_Clear) begin
        state         <= IDLE;
        Player_Number <= 4'd0;
        {TimerH, TimerL} <= GRAB_TIME;
        Lock_Out      <= 1'b0;
        Timeout_Out   <= 1'b0;
        Foul_Out      <= 1'b0;
        Buzzer_Out    <= 1'b0;
        buzz_cnt      <= '0;
        tick_cnt      <= '0;
      end else begin
        case (state)
          IDLE:
            if (|key_rise) begin
              state         <= FOUL;
              Player_Number <= pick;
              Foul_Out      <= 1'b1;
              buzz_cnt      <= BW'(TICK_DIV);
              Buzzer_Out    <= 1'b1;
            end else if (start_rise) begin
              state            <= ARMED;
              {TimerH, TimerL} <= GRAB_TIME;
              tick_cnt         <= '0;
            end
          ARMED:
            if (|key_rise) begin
              state            <= LOCKED;
              Player_Number    <= pick;
              {TimerH, TimerL} <= ANSWER_TIME;
              Lock_Out         <= 1'b1;
              buzz_cnt         <= BW'(TICK_DIV);
              Buzzer_Out       <= 1'b1;
              tick_cnt         <= '0;
            end else if (tick && timer == 8'h01) begin
              state            <= TIMEOUT;
              {TimerH, TimerL} <= 8'h00;
              Timeout_Out      <= 1'b1;
              buzz_cnt         <= BW'(TICK_DIV);
              Buzzer_Out       <= 1'b1;
              tick_cnt         <= '0;
            end else if (tick) {TimerH, TimerL} <= timer_dec;
          LOCKED:
            if (tick && timer == 8'h01) begin
              state            <= TIMEOUT;
              {TimerH, TimerL} <= 8'h00;
              Lock_Out         <= 1'b0;
              Timeout_Out      <= 1'b1;
              buzz_cnt         <= BW'(TICK_DIV);
              Buzzer_Out       <= 1'b1;
              tick_cnt         <= '0;
            end else if (tick) {TimerH, TimerL} <= timer_dec;
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_quiz_arbiter_timer.sv
// tb_quiz_arbiter_timer: directed scenarios plus randomized run against a seconds-based reference model
module tb_quiz_arbiter_timer;
  localparam int TD = 4;
  localparam int GRAB_SEC = 3;
  localparam int ANS_SEC = 5;
  localparam int M_IDLE = 0, M_ARMED = 1, M_LOCKED = 2, M_TIMEOUT = 3, M_FOUL = 4;
  logic       CLK = 1'b0, RST = 1'b0, Host_Start = 1'b0, Host_Clear = 1'b0;
  logic [7:0] Player_Key = 8'd0;
  logic [3:0] Player_Number, TimerH, TimerL;
  logic       Lock_Out, Timeout_Out, Foul_Out, Buzzer_Out;
  logic [15:0] obs;
  int checks = 0, errors = 0;
  int m_mode, m_sec, m_elapsed, m_player, m_buzz;
  logic [7:0] m_pkeys;
  logic m_pstart;
  quiz_arbiter_timer #(.TICK_DIV(TD), .GRAB_TIME(8'h03), .ANSWER_TIME(8'h05)) dut (
    .CLK(CLK), .RST(RST), .Host_Start(Host_Start), .Host_Clear(Host_Clear),
    .Player_Key(Player_Key), .Player_Number(Player_Number), .TimerH(TimerH),
    .TimerL(TimerL), .Lock_Out(Lock_Out), .Timeout_Out(Timeout_Out),
    .Foul_Out(Foul_Out), .Buzzer_Out(Buzzer_Out)
  );
  always #5 CLK = ~CLK;
  assign obs = {Player_Number, TimerH, TimerL, Lock_Out, Timeout_Out, Foul_Out, Buzzer_Out};
  // model works in whole seconds and elapsed cycles since the last state entry
  task automatic model_update(input logic r, input logic s, input logic c, input logic [7:0] k);
    logic [7:0] rises;
    logic srise, timed, tick;
    int lowest;
    rises = k & ~m_pkeys;
    srise = s & !m_pstart;
    if (r) begin
      m_mode = M_IDLE; m_sec = GRAB_SEC; m_player = 0; m_buzz = 0; m_elapsed = 0;
      m_pkeys = 8'd0; m_pstart = 1'b0;
    end else begin
      m_pkeys = k; m_pstart = s;
      timed = m_mode == M_ARMED || m_mode == M_LOCKED;
      tick = timed && (m_elapsed % TD == TD - 1);
      m_elapsed++;
      if (m_buzz > 0) m_buzz--;
      lowest = 0;
      for (int i = 7; i >= 0; i--) if (rises[i]) lowest = i + 1;
      if (c) begin
        m_mode = M_IDLE; m_sec = GRAB_SEC; m_player = 0; m_buzz = 0; m_elapsed = 0;
      end else if (m_mode == M_IDLE && rises != 0) begin
        m_mode = M_FOUL; m_player = lowest; m_buzz = TD; m_elapsed = 0;
      end else if (m_mode == M_IDLE && srise) begin
        m_mode = M_ARMED; m_sec = GRAB_SEC; m_elapsed = 0;
      end else if (m_mode == M_ARMED && rises != 0) begin
        m_mode = M_LOCKED; m_player = lowest; m_sec = ANS_SEC; m_buzz = TD; m_elapsed = 0;
      end else if (tick) begin
        if (m_sec == 1) begin
          m_mode = M_TIMEOUT; m_sec = 0; m_buzz = TD; m_elapsed = 0;
        end else if (m_sec > 0) m_sec--;
      end
    end
  endtask
  function automatic logic [15:0] model_vec();
    return {4'(m_player), 4'(m_sec / 10), 4'(m_sec % 10), m_mode == M_LOCKED,
            m_mode == M_TIMEOUT, m_mode == M_FOUL, m_buzz > 0};
  endfunction
  task automatic step(input logic r, input logic s, input logic c, input logic [7:0] k);
    RST = r; Host_Start = s; Host_Clear = c; Player_Key = k;
    @(posedge CLK);
    model_update(r, s, c, k);
    #1;
  endtask
  task automatic test_reset();
    step(1, 0, 0, 8'd0);
    checks++;
    if (obs !== 16'h0030) begin errors++; $display("FAIL reset obs=%h exp=%h", obs, 16'h0030); end
  endtask
  task automatic test_timeout();
    int bcnt = 0;
    step(0, 1, 0, 8'd0);
    for (int c = 1; c <= 16; c++) begin
      step(0, 0, 0, 8'd0);
      if (c >= 12 && Buzzer_Out === 1'b1) bcnt++;
      if (c == 3) begin
        checks++;
        if (obs !== 16'h0030) begin errors++; $display("FAIL grab_first_second obs=%h exp=%h", obs, 16'h0030); end
      end
      if (c == 4) begin
        checks++;
        if (obs !== 16'h0020) begin errors++; $display("FAIL grab_t02 obs=%h exp=%h", obs, 16'h0020); end
      end
      if (c == 8) begin
        checks++;
        if (obs !== 16'h0010) begin errors++; $display("FAIL grab_t01 obs=%h exp=%h", obs, 16'h0010); end
      end
      if (c == 12) begin
        checks++;
        if (obs !== 16'h0005) begin errors++; $display("FAIL grab_timeout obs=%h exp=%h", obs, 16'h0005); end
      end
      if (c == 16) begin
        checks++;
        if (obs !== 16'h0004) begin errors++; $display("FAIL timeout_hold obs=%h exp=%h", obs, 16'h0004); end
      end
    end
    checks++;
    if (bcnt != TD) begin errors++; $display("FAIL buzzer_len got=%0d exp=%0d", bcnt, TD); end
  endtask
  task automatic test_lock();
    step(0, 0, 1, 8'd0);
    step(0, 1, 0, 8'd0);
    step(0, 0, 0, 8'd0);
    step(0, 0, 0, 8'd0);
    step(0, 0, 0, 8'h14);
    checks++;
    if (obs !== 16'h3059) begin errors++; $display("FAIL lock_entry obs=%h exp=%h", obs, 16'h3059); end
    for (int c = 1; c <= 20; c++) begin
      step(0, 0, 0, c < 5 ? 8'h14 : 8'h15);
      if (c == 6) begin
        checks++;
        if (obs !== 16'h3048) begin errors++; $display("FAIL lock_ignore_key obs=%h exp=%h", obs, 16'h3048); end
      end
      if (c == 19) begin
        checks++;
        if (obs !== 16'h3018) begin errors++; $display("FAIL lock_t01 obs=%h exp=%h", obs, 16'h3018); end
      end
      if (c == 20) begin
        checks++;
        if (obs !== 16'h3005) begin errors++; $display("FAIL lock_timeout obs=%h exp=%h", obs, 16'h3005); end
      end
    end
  endtask
  task automatic test_foul();
    step(0, 0, 1, 8'd0);
    step(0, 0, 0, 8'h40);
    checks++;
    if (obs !== 16'h7033) begin errors++; $display("FAIL foul_entry obs=%h exp=%h", obs, 16'h7033); end
    step(0, 0, 0, 8'd0);
    step(0, 1, 0, 8'd0);
    for (int c = 0; c < 5; c++) step(0, 0, 0, 8'd0);
    checks++;
    if (obs !== 16'h7032) begin errors++; $display("FAIL foul_ignore_start obs=%h exp=%h", obs, 16'h7032); end
    step(0, 0, 1, 8'd0);
    checks++;
    if (obs !== 16'h0030) begin errors++; $display("FAIL foul_clear obs=%h exp=%h", obs, 16'h0030); end
  endtask
  task automatic test_held_key();
    step(0, 0, 1, 8'h01);
    step(0, 1, 0, 8'h01);
    checks++;
    if (obs !== 16'h0030) begin errors++; $display("FAIL held_armed obs=%h exp=%h", obs, 16'h0030); end
    for (int c = 1; c <= 12; c++) step(0, 0, 0, 8'h01);
    checks++;
    if (obs !== 16'h0005) begin errors++; $display("FAIL held_timeout obs=%h exp=%h", obs, 16'h0005); end
  endtask
  task automatic test_key_on_expiry();
    step(0, 0, 1, 8'd0);
    step(0, 1, 0, 8'd0);
    for (int c = 1; c <= 11; c++) step(0, 0, 0, 8'd0);
    checks++;
    if (obs !== 16'h0010) begin errors++; $display("FAIL expiry_pre obs=%h exp=%h", obs, 16'h0010); end
    step(0, 0, 0, 8'h02);
    checks++;
    if (obs !== 16'h2059) begin errors++; $display("FAIL key_beats_expiry obs=%h exp=%h", obs, 16'h2059); end
  endtask
  task automatic test_reset_mid_lock();
    for (int c = 1; c <= 4; c++) step(0, 0, 0, 8'h02);
    checks++;
    if (obs !== 16'h2048) begin errors++; $display("FAIL lock_t04 obs=%h exp=%h", obs, 16'h2048); end
    step(1, 0, 0, 8'h02);
    checks++;
    if (obs !== 16'h0030) begin errors++; $display("FAIL reset_mid_lock obs=%h exp=%h", obs, 16'h0030); end
  endtask
  task automatic test_random();
    logic [7:0] keys = 8'd0;
    logic [15:0] exp_v;
    step(1, 0, 0, 8'd0);
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 9) == 0) keys = keys ^ (8'd1 << $urandom_range(0, 7));
      step($urandom_range(0, 199) == 0, $urandom_range(0, 7) == 0,
           $urandom_range(0, 39) == 0, keys);
      exp_v = model_vec();
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL random cycle=%0d obs=%h exp=%h", n, obs, exp_v);
      end
    end
  endtask
  initial begin
    test_reset();
    test_timeout();
    test_lock();
    test_foul();
    test_held_key();
    test_key_on_expiry();
    test_reset_mid_lock();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
